spi_segment_mux: RTL and testbench

SPI_SEGMENT_MUX -- requirements
Module: spi_segment_mux

---
 rtl/spi_segment_mux.sv | 142 ++++++++++++++
 tb/tb_spi_segment_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_segment_mux.sv
// SPI-programmed multiplexed 7-segment display driver with per-slot PWM brightness.
// A 16-bit SPI mode-0 frame writes digit, brightness, enable or clear registers.
module spi_segment_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] dig_en,
   output logic                  frame_done
);
   localparam int              SW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [4:0]      ND       = 5'(NUM_DIGITS);
   localparam logic [15:0]     PRE_MAX  = 16'(TICK_DIV - 1);
   localparam logic [SW-1:0]   SCAN_MAX = SW'(NUM_DIGITS - 1);

   typedef enum logic [3:0] {
      CMD_RAW    = 4'h1,
      CMD_HEX    = 4'h2,
      CMD_BRIGHT = 4'h3,
      CMD_ENABLE = 4'h4,
      CMD_CLEAR  = 4'h5
   } cmd_e;

   logic [1:0]            sclk_sync, cs_sync, mosi_sync;
   logic                  sclk_prev, cs_prev;
   logic                  sclk_rise, cs_fall, cs_low;
   logic [4:0]            bit_cnt;
   logic [15:0]           shift;
   logic                  frame_ready;
   logic                  idx_ok;
   logic [7:0]            digit [NUM_DIGITS];
   logic [3:0]            brightness;
   logic                  enable;
   logic [15:0]           presc;
   logic [3:0]            phase;
   logic [SW-1:0]         scan;
   logic [NUM_DIGITS-1:0] dig_next;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[0], sclk};
         cs_sync   <= {cs_sync[0], cs_n};
         mosi_sync <= {mosi_sync[0], mosi};
         sclk_prev <= sclk_sync[1];
         cs_prev   <= cs_sync[1];
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_prev;
   assign cs_fall   = ~cs_sync[1] & cs_prev;
   assign cs_low    = ~cs_sync[1];

   // bit_cnt saturates at 16 so trailing bits are ignored until cs_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         shift       <= '0;
         frame_ready <= 1'b0;
      end else begin
         frame_ready <= 1'b0;
         if (!cs_low || cs_fall) begin
            bit_cnt <= '0;
         end else if (sclk_rise && bit_cnt != 5'd16) begin
            shift       <= {shift[14:0], mosi_sync[1]};
            bit_cnt     <= bit_cnt + 5'd1;
            frame_ready <= (bit_cnt == 5'd15);
         end
      end
   end

   assign idx_ok = ({1'b0, shift[11:8]} < ND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
         brightness <= '1;
         enable     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_ready;
         if (frame_ready) begin
            case (shift[15:12])
               CMD_RAW:    if (idx_ok) digit[shift[8+SW-1:8]] <= shift[7:0];
               CMD_HEX:    if (idx_ok) digit[shift[8+SW-1:8]] <= {shift[7], hex7(shift[3:0])};
               CMD_BRIGHT: brightness <= shift[3:0];
               CMD_ENABLE: enable <= shift[0];
               CMD_CLEAR:  for (int unsigned i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
               default:    ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         phase <= '0;
         scan  <= '0;
      end else if (presc == PRE_MAX) begin
         presc <= '0;
         phase <= phase + 4'd1;
         if (phase == 4'hF) scan <= (scan == SCAN_MAX) ? '0 : scan + 1'b1;
      end else begin
         presc <= presc + 16'd1;
      end
   end

   always_comb begin
      dig_next = '0;
      if (enable && phase <= brightness) dig_next[scan] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg    <= '0;
         dig_en <= '0;
      end else begin
         seg    <= (dig_next != '0) ? digit[scan] : '0;
         dig_en <= dig_next;
      end
   end
endmodule

// File: tb/tb_spi_segment_mux.sv
// Bench for spi_segment_mux: frames are queued on send and applied to a reference
// display model when frame_done fires; outputs are compared every cycle.
module tb_spi_segment_mux;
   localparam int ND = 4;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sclk = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic [7:0]    seg;
   logic [ND-1:0] dig_en;
   logic          frame_done;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] sbq [$];
   logic [7:0]  m_dig [ND];
   logic [3:0]  m_bright;
   logic        m_en;
   int          cyc = 0;
   int          done_cnt = 0;
   logic        prev_fd = 1'b0;
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   spi_segment_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
      m_bright = 4'hF;
      m_en     = 1'b1;
   endtask

   task automatic model_apply(input logic [15:0] w);
      logic [3:0] cmd, idx;
      logic [7:0] data;
      cmd = w[15:12]; idx = w[11:8]; data = w[7:0];
      case (cmd)
         4'h1: if (idx < ND) m_dig[idx] = data;
         4'h2: if (idx < ND) m_dig[idx] = {data[7], hex_tab[data[3:0]]};
         4'h3: m_bright = data[3:0];
         4'h4: m_en = data[0];
         4'h5: for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
         default: ;
      endcase
   endtask

   // Reference display: slot timing derived purely from cycles since reset release
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out", {19'd0, frame_done, dig_en, seg}, 32'd0);
         model_reset();
         cyc     = 0;
         prev_fd = 1'b0;
      end else begin
         int ph, sc;
         logic [3:0] e_en;
         logic [7:0] e_seg;
         ph    = (cyc / TD) % 16;
         sc    = (cyc / (TD * 16)) % ND;
         e_en  = (m_en && ph <= int'(m_bright)) ? (4'b0001 << sc) : 4'b0000;
         e_seg = (e_en != 4'b0) ? m_dig[sc] : 8'h00;
         check("scan", {20'd0, dig_en, seg}, {20'd0, e_en, e_seg});
         if (frame_done) begin
            check("fd_width", {31'd0, prev_fd}, 32'd0);
            check("sb_nonempty", {31'd0, sbq.size() > 0}, 32'd1);
            if (sbq.size() > 0) model_apply(sbq.pop_front());
            done_cnt++;
         end
         prev_fd = frame_done;
         cyc++;
      end
   end

   task automatic spi_send(input logic [15:0] w, input int nbits, input bit push);
      if (push) sbq.push_back(w);
      @(negedge clk); cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 16) ? w[15-i] : 1'b1;
         repeat (5) @(negedge clk); sclk = 1'b1;
         repeat (5) @(negedge clk); sclk = 1'b0;
      end
      repeat (5) @(negedge clk); cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
      check(tag, sbq.size(), 32'd0);
   endtask

   task automatic wait_dig(input logic [3:0] d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (dig_en == d) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      int base, active;
      bit ok;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("first_slot", {28'd0, dig_en}, 32'd1);
      repeat (300) @(negedge clk);

      base = done_cnt;
      spi_send(16'h2105, 16, 1'b1);
      wait_done("done_2105");
      check("fd_once_2105", done_cnt - base, 32'd1);
      wait_dig(4'b0010, ok);
      check("wait_d1", {31'd0, ok}, 32'd1);
      check("hex5_seg", {24'd0, seg}, 32'h6D);

      spi_send(16'h3003, 16, 1'b1);
      wait_done("done_3003");
      active = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (dig_en != '0) active++;
      end
      check("pwm_active", active, 32'd64);

      base = done_cnt;
      spi_send(16'h1007, 9, 1'b0);
      repeat (40) @(negedge clk);
      check("partial_nodone", done_cnt - base, 32'd0);
      spi_send(16'h1007, 16, 1'b1);
      wait_done("done_1007");
      spi_send(16'h300F, 16, 1'b1);
      wait_done("done_300F");
      wait_dig(4'b0001, ok);
      check("d0_raw", {23'd0, ok, seg}, {23'd0, 1'b1, 8'h07});

      base = done_cnt;
      spi_send(16'h1480, 16, 1'b1);
      spi_send(16'h9123, 16, 1'b1);
      wait_done("done_bad");
      check("bad_done_cnt", done_cnt - base, 32'd2);

      spi_send(16'h4000, 16, 1'b1);
      wait_done("done_4000");
      active = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (dig_en != '0) active++;
      end
      check("disabled", active, 32'd0);
      spi_send(16'h4001, 16, 1'b1);
      wait_done("done_4001");

      spi_send(16'h1355, 16, 1'b1);
      spi_send(16'h238A, 16, 1'b1);
      spi_send(16'h1199, 20, 1'b1);
      wait_done("done_writes");
      repeat (300) @(negedge clk);
      spi_send(16'h5000, 16, 1'b1);
      wait_done("done_clear");
      repeat (100) @(negedge clk);
      spi_send(16'h1111, 16, 1'b1);
      spi_send(16'h2222, 16, 1'b1);
      wait_done("done_pre_rst");
      repeat (150) @(negedge clk);

      @(negedge clk); cs_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mosi = 1'b1;
         repeat (5) @(negedge clk); sclk = 1'b1;
         repeat (5) @(negedge clk); sclk = 1'b0;
      end
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check("rst_async", {19'd0, frame_done, dig_en, seg}, 32'd0);
      cs_n = 1'b1; mosi = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("scan_restart", {28'd0, dig_en}, 32'd1);
      base = done_cnt;
      spi_send(16'h1042, 16, 1'b1);
      wait_done("done_post_rst");
      check("post_rst_cnt", done_cnt - base, 32'd1);
      repeat (300) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
